// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
//
// Purpose:
//   Instruction fetch memory with a valid/ready request channel and a
//   valid/ready response channel. After every reset release the memory is
//   cleared one word per cycle (INIT). Each accepted fetch returns its word
//   LATENCY cycles later, or an error with zero data for a misaligned or
//   out-of-range byte address. Only one fetch is in flight at a time.
//
// Parameters:
//   MEM_DEPTH  - number of words (power of two, >= 4)
//   DATA_WIDTH - instruction word width
//   LATENCY    - cycles from request accept to resp_valid (1..8)
//
// Ports:
//   clk         in   single clock, all state on the rising edge
//   reset       in   asynchronous, active-low reset
//   req_valid   in   fetch request present
//   req_ready   out  high only in IDLE; accept = req_valid & req_ready
//   req_addr    in   32-bit byte address, word index = req_addr[AW+1:2]
//   resp_valid  out  response present, held until resp_ready
//   resp_ready  in   consumer takes the response
//   resp_data   out  instruction word (0 on error)
//   resp_err    out  misaligned or out-of-range fetch
//   busy        out  high whenever the FSM is not in IDLE
//
// Optional feature (macro IMEM_WRITE_PORT_EN):
//   wr_en       in   program-load write strobe, honoured only in IDLE
//   wr_addr     in   32-bit byte address, must be aligned and in range
//   wr_data     in   word to write
//   A fetch accepted on the same edge as a write to the same word returns
//   the old contents.
// -----------------------------------------------------------------------------
module instr_fetch_mem #(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  busy
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic                  wr_en,
  input  logic [31:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  // Number of byte-address bits above the word index; any of them set
  // means the address is at or beyond 4*MEM_DEPTH.
  localparam int HW = 30 - AW;

  localparam logic [AW-1:0] IDX_LAST = AW'(MEM_DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_ZERO = AW'(0);
  localparam logic [2:0]    CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Misaligned or out-of-range byte address.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr[31:AW+2] != {HW{1'b0}});
    addr_bad     = misaligned | out_of_range;
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic [AW-1:0]         init_idx_r;
  logic [AW-1:0]         init_idx_next_s;
  logic [2:0]            cnt_r;
  logic [2:0]            cnt_next_s;
  logic [DATA_WIDTH-1:0] resp_data_r;
  logic [DATA_WIDTH-1:0] resp_data_next_s;
  logic                  resp_err_r;
  logic                  resp_err_next_s;
  logic                  resp_valid_r;
  logic                  req_ready_r;
  logic                  busy_r;

  logic                  mem_we_s;
  logic [AW-1:0]         mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  req_bad_s;

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  assign rd_data_s = mem_r[req_addr[AW+1:2]];
  assign req_bad_s = addr_bad(req_addr);

  // Next-state, capture and memory-write decode.
  always_comb begin
    state_next_s     = state_r;
    init_idx_next_s  = init_idx_r;
    cnt_next_s       = cnt_r;
    resp_data_next_s = resp_data_r;
    resp_err_next_s  = resp_err_r;
    mem_we_s         = 1'b0;
    mem_waddr_s      = IDX_ZERO;
    mem_wdata_s      = {DATA_WIDTH{1'b0}};

    case (state_r)
      INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = init_idx_r;
        if (init_idx_r == IDX_LAST) begin
          state_next_s    = IDLE;
          init_idx_next_s = IDX_ZERO;
        end else begin
          init_idx_next_s = init_idx_r + IDX_ONE;
        end
      end

      IDLE: begin
`ifdef IMEM_WRITE_PORT_EN
        if (wr_en && !addr_bad(wr_addr)) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = wr_addr[AW+1:2];
          mem_wdata_s = wr_data;
        end else begin
          mem_we_s    = 1'b0;
        end
`endif
        if (req_valid) begin
          // rd_data_s is the pre-write word, so a same-edge write to the
          // same address is not visible to this fetch.
          resp_err_next_s  = req_bad_s;
          resp_data_next_s = req_bad_s ? {DATA_WIDTH{1'b0}} : rd_data_s;
          cnt_next_s       = CNT_INIT;
          state_next_s     = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end

      WAIT: begin
        // The countdown reaching 0 on this edge makes resp_valid appear
        // exactly LATENCY cycles after the accept.
        if (cnt_r <= 3'd1) begin
          cnt_next_s   = 3'd0;
          state_next_s = RESP;
        end else begin
          cnt_next_s   = cnt_r - 3'd1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end

      default: begin
        state_next_s    = INIT;
        init_idx_next_s = IDX_ZERO;
      end
    endcase
  end

  // State, capture registers and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= INIT;
      init_idx_r   <= IDX_ZERO;
      cnt_r        <= 3'd0;
      resp_data_r  <= {DATA_WIDTH{1'b0}};
      resp_err_r   <= 1'b0;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      init_idx_r   <= init_idx_next_s;
      cnt_r        <= cnt_next_s;
      resp_data_r  <= resp_data_next_s;
      resp_err_r   <= resp_err_next_s;
      resp_valid_r <= (state_next_s == RESP);
      req_ready_r  <= (state_next_s == IDLE);
      busy_r       <= (state_next_s != IDLE);
    end
  end

  // Memory array: INIT clearing and program-load writes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
//
// Purpose:
//   Self-checking bench for instr_fetch_mem (MEM_DEPTH=1024, LATENCY=3).
//   A reference model (a word array plus the address-validity rule) predicts
//   every response. Directed steps cover reset, INIT length, latency,
//   error addresses, back-pressure and reset mid-fetch; a randomized phase
//   mixes valid, misaligned, out-of-range and boundary addresses.
//   Build with +define+IMEM_WRITE_PORT_EN to also exercise the write port.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;

  localparam int MEM_DEPTH  = 1024;
  localparam int DATA_WIDTH = 32;
  localparam int LATENCY    = 3;

  logic                  clk;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  busy;
`ifdef IMEM_WRITE_PORT_EN
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
`endif

  int passed;
  int failed;
  int total;

  logic [DATA_WIDTH-1:0] model_mem [MEM_DEPTH];

  instr_fetch_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy)
`ifdef IMEM_WRITE_PORT_EN
    ,
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A fetch errors when it is not word aligned or lies beyond the memory.
  function automatic bit model_err(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || (longint'(a) >= 4 * longint'(MEM_DEPTH));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] model_read(input logic [31:0] a);
    if (model_err(a)) return '0;
    else return model_mem[a / 32'd4];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd4;
    case ($urandom_range(0, 3))
      0: return w;
      1: return w + 32'($urandom_range(1, 3));
      2: return 32'(4 * MEM_DEPTH) + 32'($urandom_range(0, 4000));
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'(4 * MEM_DEPTH - 4);
          1: return 32'(4 * MEM_DEPTH);
          2: return 32'h0000_0000;
          default: return 32'hFFFF_FFFC;
        endcase
      end
    endcase
  endfunction

  // Release reset at a falling edge and measure how many rising edges pass
  // before busy drops; no response may appear meanwhile.
  task automatic release_and_init();
    int cnt;
    bit seen_resp;
    cnt = 0;
    seen_resp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (resp_valid) seen_resp = 1'b1;
    end while (busy && cnt < 3 * MEM_DEPTH);
    check("init_cycles", 64'(cnt), 64'(MEM_DEPTH));
    check("init_req_ready", 64'(req_ready), 64'd1);
    check("init_no_resp", 64'(seen_resp), 64'd0);
    model_clear();
  endtask

`ifdef IMEM_WRITE_PORT_EN
  // Single write issued while idle.
  task automatic do_write(input logic [31:0] a, input logic [DATA_WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (!model_err(a)) model_mem[a / 32'd4] = d;
  endtask
`endif

  // Waits for the response of a fetch accepted on the last edge, then
  // checks latency, payload and the stall/release behaviour.
  task automatic finish_fetch(input string tag, input logic [DATA_WIDTH-1:0] exp_d,
                              input bit exp_e, input int stall);
    int cnt;
    cnt = 1;
    while (!resp_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    req_valid = 1'b0;
`ifdef IMEM_WRITE_PORT_EN
    wr_en = 1'b0;
`endif
    check({tag, "_latency"}, 64'(cnt), 64'(LATENCY));
    check({tag, "_data"}, 64'(resp_data), 64'(exp_d));
    check({tag, "_err"}, 64'(resp_err), 64'(exp_e));
    check({tag, "_ready_busy"}, {62'd0, req_ready, busy}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_data"}, {31'd0, resp_err, resp_data}, {31'd0, exp_e, exp_d});
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release"}, {62'd0, resp_valid, req_ready}, 64'd1);
    resp_ready = 1'b0;
  endtask

  // Full fetch; optionally drives ignored traffic while the block is busy.
  task automatic fetch(input string tag, input logic [31:0] a, input int stall, input bit junk);
    logic [DATA_WIDTH-1:0] exp_d;
    bit exp_e;
    exp_e = model_err(a);
    exp_d = model_read(a);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = junk;
    req_addr  = gen_addr();
`ifdef IMEM_WRITE_PORT_EN
    wr_en   = junk;
    wr_addr = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd4;
    wr_data = $urandom;
`endif
    finish_fetch(tag, exp_d, exp_e, stall);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
`ifdef IMEM_WRITE_PORT_EN
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = '0;
`endif
    model_clear();

    // Reset state, asserted before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_resp", {31'd0, resp_err, resp_data}, 64'd0);
    check("rst_flags", {61'd0, resp_valid, req_ready, busy}, 64'd1);
    repeat (3) @(negedge clk);
    release_and_init();

    // Directed fetches: valid address, misaligned, just out of range,
    // last valid word, back-pressure.
    fetch("fetch_0x8", 32'h0000_0008, 0, 1'b0);
    fetch("fetch_0x6", 32'h0000_0006, 0, 1'b0);
    fetch("fetch_0x1000", 32'h0000_1000, 0, 1'b0);
    fetch("fetch_0xffc", 32'h0000_0FFC, 0, 1'b0);
    fetch("stall5", 32'h0000_0004, 5, 1'b1);

`ifdef IMEM_WRITE_PORT_EN
    do_write(32'h0000_0010, 32'h0050_0093);
    fetch("wr_fetch_0x10", 32'h0000_0010, 0, 1'b0);
    do_write(32'h0000_0014, 32'h1234_5678);
    do_write(32'h0000_0015, 32'hDEAD_BEEF);
    do_write(32'h0000_1014, 32'hDEAD_BEEF);
    // Same-edge write and fetch of 0x14 returns the old word.
    begin
      logic [DATA_WIDTH-1:0] old_d;
      old_d = model_read(32'h0000_0014);
      req_valid = 1'b1; req_addr = 32'h0000_0014; resp_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 32'h0000_0014; wr_data = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0; wr_en = 1'b0;
      model_mem[5] = 32'hCAFE_F00D;
      finish_fetch("rbw_0x14", old_d, 1'b0, 0);
    end
    fetch("after_rbw_0x14", 32'h0000_0014, 0, 1'b0);
`endif

    // Randomized phase.
    for (int t = 0; t < 30; t++) begin
`ifdef IMEM_WRITE_PORT_EN
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] wa;
        wa = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd4;
        if ($urandom_range(0, 3) == 0) wa = wa + 32'd2;
        do_write(wa, $urandom);
      end
`endif
      fetch("rand", gen_addr(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fetch drops it and reruns INIT.
    req_valid = 1'b1; req_addr = 32'h0000_0008; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_flags", {61'd0, resp_valid, req_ready, busy}, 64'd1);
    check("mid_rst_resp", {31'd0, resp_err, resp_data}, 64'd0);
    repeat (2) @(negedge clk);
    release_and_init();
    resp_ready = 1'b0;
    fetch("post_rst_0x10", 32'h0000_0010, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
